score_keeper: RTL
=================

Name: score_keeper

Overview:
- Sequential producer of the per-game scoreboard: consumes one round result per handshake, accumulates round/win/lose counts, and declares game end with a winner code.
- Its round/win/lose outputs drive the finish-detect logic and the display path.
- Its fin/printwinner outputs use the same encoding the finish-detect logic produces, so the two are interchangeable for display and cross-checkable in verification.

Parameters:
- MAX_ROUND, 9, number of rounds per game; range 1..15 (must fit 4 bits).
- CNT_W, 4, width of round/win/lose counters; fixed at 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears scoreboard and begins a new game.
- res_valid  in  1  round result offered this cycle.
- res  in  2  round result: 01 = P1 wins round, 10 = P2 wins round, 11 = draw, 00 = illegal.
- res_ready  out  1  block accepts a result this cycle (high only in PLAY).
- round  out  4  rounds completed this game.
- win  out  4  rounds won by P1.
- lose  out  4  rounds won by P2.
- fin  out  1  game finished.
- printwinner  out  2  00 = not finished, 10 = P1 winner, 11 = P2 winner, 01 = tie.
- err  out  1  one-cycle pulse when an illegal result (00) is offered while ready.

Behaviour:
- Reset, asynchronous: state = IDLE; round = win = lose = 0; fin = 0; printwinner = 00; err = 0; res_ready = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, PLAY, DONE.
- IDLE: res_ready = 0, counters hold.
  - start -> counters cleared, go PLAY on the next edge.
- PLAY: res_ready = 1.
  - Transfer occurs when res_valid && res_ready.
  - On transfer with res = 01: win+1, round+1.
  - On transfer with res = 10: lose+1, round+1.
  - On transfer with res = 11: round+1 only.
  - On transfer with res = 00: no counter change; err pulses high for one cycle on the next edge.
- Finish detection uses the next-state round value. If a legal transfer makes round == MAX_ROUND:
  - On the same edge: fin = 1, state = DONE, res_ready = 0.
  - On the same edge, printwinner is computed from the updated win/lose: win > lose -> 10; lose > win -> 11; equal -> 01.
- Latency: the updated counts, fin and printwinner are all visible the cycle after the accepting edge.
- Invariant: round == win + lose + draws. Counters never exceed MAX_ROUND, so no wrap-around is possible.
- DONE: res_ready = 0. res_valid is ignored with no err; counts, fin and printwinner hold.
  - start -> clear all, fin = 0, printwinner = 00, go PLAY.
- start in PLAY: aborts the game. Counters clear, stays PLAY, and any same-cycle result is dropped (start has priority).
- start in IDLE or DONE together with res_valid: the result is dropped.
- printwinner is 00 whenever fin = 0.
- Reset asserted mid-game returns to IDLE immediately, without waiting for the clock edge.

Decomposition:
- Shared package/header holds:
  - result codes RES_NONE = 00, RES_P1 = 01, RES_P2 = 10, RES_DRAW = 11;
  - winner codes WIN_NONE = 00, WIN_TIE = 01, WIN_P1 = 10, WIN_P2 = 11;
  - state encodings IDLE / PLAY / DONE;
  - default MAX_ROUND.
- One natural sub-module: winner_decode, a combinational compare of win vs lose that yields the winner code. It is reused by the display path.

Test Plan:
- Reset then start; feed 9 results: six 01, two 10, one 11 -> after the 9th accept: round = 1001, win = 0110, lose = 0010, fin = 1, printwinner = 10, res_ready = 0.
- Start; feed 01, 10 alternating 8 times, then 11 -> round = 9, win = 4, lose = 4, fin = 1, printwinner = 01. After only 8 results: round = 1000, fin = 0, printwinner = 00.
- Start; feed two 01, six 10, one 11 -> fin = 1, printwinner = 11. Further res_valid in DONE leaves counts unchanged and err = 0.
- In PLAY offer res = 00 -> err is high for exactly one cycle; round/win/lose unchanged. A following 01 increments win and round normally.
- After 5 rounds (win = 2, lose = 3) pulse start with res_valid = 1 -> all counters 0, fin = 0, state PLAY, result not counted.
- Assert rst_n low mid-game between clock edges -> outputs go to reset values immediately; res_ready = 0 until the next start.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper: result/winner codes, FSM states
// and default sizing.
package score_keeper_pkg;

  localparam int DEFAULT_CNT_W     = 4;
  localparam int DEFAULT_MAX_ROUND = 9;

  // Round result codes offered on the result bus
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Winner codes shared with the finish-detect logic and display path
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TIE  = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  // A result of 00 carries no round outcome and is flagged as an error
  function automatic logic is_legal_res(input logic [1:0] r);
    return r != RES_NONE;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Valid/ready result bus between the round judge and the score keeper.
interface score_keeper_if;

  logic       res_valid;
  logic [1:0] res;
  logic       res_ready;

  modport master (output res_valid, output res, input res_ready);
  modport slave  (input res_valid, input res, output res_ready);

endinterface

// File: rtl/score_keeper_winner_decode.sv
// Compares P1 wins against P2 wins and yields the winner code.
// Also reused by the display path, so it carries no notion of "finished".
module winner_decode
  import score_keeper_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [CNT_W-1:0] win,
  input  logic [CNT_W-1:0] lose,
  output logic [1:0]       winner
);

  // Pure magnitude compare; equal counts are reported as a tie
  always_comb begin
    winner = WIN_TIE;
    if (win > lose) begin
      winner = WIN_P1;
    end else if (lose > win) begin
      winner = WIN_P2;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Per-game scoreboard: accepts one round result per handshake, counts
// rounds/wins/losses and declares the winner once MAX_ROUND rounds are in.
// Every output comes straight from a flop.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int MAX_ROUND = DEFAULT_MAX_ROUND,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  score_keeper_if.slave     res_bus,
  output logic [CNT_W-1:0]  round,
  output logic [CNT_W-1:0]  win,
  output logic [CNT_W-1:0]  lose,
  output logic              fin,
  output logic [1:0]        printwinner,
  output logic              err
);

  state_t           state;
  state_t           next_state;
  logic             res_ready_q;
  logic             take;

  logic [CNT_W-1:0] upd_round;
  logic [CNT_W-1:0] upd_win;
  logic [CNT_W-1:0] upd_lose;
  logic [1:0]       upd_winner;

  logic [CNT_W-1:0] next_round;
  logic [CNT_W-1:0] next_win;
  logic [CNT_W-1:0] next_lose;
  logic             next_fin;
  logic [1:0]       next_pw;
  logic             next_err;

  assign res_bus.res_ready = res_ready_q;

  // Ready is only ever high in PLAY, so this is the transfer qualifier
  assign take = res_bus.res_valid && res_ready_q;

  // Counter values as they would be after accepting the offered legal result
  always_comb begin
    upd_round = round + CNT_W'(1);
    upd_win   = win;
    upd_lose  = lose;
    if (res_bus.res == RES_P1) begin
      upd_win = win + CNT_W'(1);
    end
    if (res_bus.res == RES_P2) begin
      upd_lose = lose + CNT_W'(1);
    end
  end

  // Winner judged on post-accept counts so fin and printwinner land together
  winner_decode #(
    .CNT_W (CNT_W)
  ) u_winner_decode (
    .win    (upd_win),
    .lose   (upd_lose),
    .winner (upd_winner)
  );

  // Next-state and next-scoreboard logic; start always wins over a result
  always_comb begin
    next_state = state;
    next_round = round;
    next_win   = win;
    next_lose  = lose;
    next_fin   = fin;
    next_pw    = printwinner;
    next_err   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          next_round = '0;
          next_win   = '0;
          next_lose  = '0;
          next_fin   = 1'b0;
          next_pw    = WIN_NONE;
          next_state = PLAY;
        end
      end

      PLAY: begin
        if (start) begin
          next_round = '0;
          next_win   = '0;
          next_lose  = '0;
          next_fin   = 1'b0;
          next_pw    = WIN_NONE;
        end else if (take) begin
          if (!is_legal_res(res_bus.res)) begin
            next_err = 1'b1;
          end else begin
            next_round = upd_round;
            next_win   = upd_win;
            next_lose  = upd_lose;
            if (upd_round == CNT_W'(MAX_ROUND)) begin
              next_fin   = 1'b1;
              next_pw    = upd_winner;
              next_state = DONE;
            end
          end
        end
      end

      DONE: begin
        if (start) begin
          next_round = '0;
          next_win   = '0;
          next_lose  = '0;
          next_fin   = 1'b0;
          next_pw    = WIN_NONE;
          next_state = PLAY;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, scoreboard and handshake registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      round       <= '0;
      win         <= '0;
      lose        <= '0;
      fin         <= 1'b0;
      printwinner <= WIN_NONE;
      err         <= 1'b0;
      res_ready_q <= 1'b0;
    end else begin
      state       <= next_state;
      round       <= next_round;
      win         <= next_win;
      lose        <= next_lose;
      fin         <= next_fin;
      printwinner <= next_pw;
      err         <= next_err;
      res_ready_q <= (next_state == PLAY);
    end
  end

endmodule
